// File: rtl/joypad_event_queue_pkg.sv
// Shared definitions for the joypad event queue: button indices, event layout
// and default parameters.
package joypad_event_queue_pkg;

  typedef enum logic [3:0] {
    BTN_UP     = 4'd0,
    BTN_DOWN   = 4'd1,
    BTN_LEFT   = 4'd2,
    BTN_RIGHT  = 4'd3,
    BTN_A      = 4'd4,
    BTN_B      = 4'd5,
    BTN_X      = 4'd6,
    BTN_Y      = 4'd7,
    BTN_L      = 4'd8,
    BTN_R      = 4'd9,
    BTN_SELECT = 4'd10,
    BTN_START  = 4'd11
  } btn_e;

  localparam int unsigned NUM_BTN      = int'(BTN_START) + 1;
  localparam int unsigned EV_W         = 6;
  localparam int unsigned EV_IDX_LSB   = 0;
  localparam int unsigned EV_IDX_W     = 4;
  localparam int unsigned EV_PRESS_BIT = 4;
  localparam int unsigned EV_PAD_BIT   = 5;
  localparam int unsigned COUNT_W      = 5;
  localparam int unsigned DEBOUNCE_DEF = 16;
  localparam int unsigned DEPTH_DEF    = 8;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  function automatic logic [EV_W-1:0] pack_event(input logic pad, input logic pressed,
                                                 input logic [EV_IDX_W-1:0] idx);
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_PAD_BIT]                 = pad;
    ev[EV_PRESS_BIT]               = pressed;
    ev[EV_IDX_LSB +: EV_IDX_W]     = idx;
    return ev;
  endfunction

endpackage

// File: rtl/joypad_event_queue_fifo.sv
// Synchronous show-ahead event FIFO; a push into a full FIFO is accepted only
// when the head is popped in the same cycle.
module joypad_event_fifo
  import joypad_event_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [EV_W-1:0]    data_i,
  input  logic               pop_i,
  output logic [EV_W-1:0]    data_o,
  output logic               valid_o,
  output logic               full_o,
  output logic [COUNT_W-1:0] count_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EV_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == COUNT_W'(DEPTH));
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign do_pop  = pop_i & valid_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/joypad_event_queue.sv
// Two-pad joypad debouncer with change scanner feeding a press/release event FIFO.
module joypad_event_queue
  import joypad_event_queue_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               res,
  input  logic [NUM_BTN-1:0] button_data_1,
  input  logic [NUM_BTN-1:0] button_data_2,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [EV_W-1:0]    ev_data,
  output logic [COUNT_W-1:0] ev_count,
  output logic [NUM_BTN-1:0] held_1,
  output logic [NUM_BTN-1:0] held_2
);
  localparam logic [7:0]  DEB = 8'(DEBOUNCE);
  localparam int unsigned NB2 = 2 * NUM_BTN;

  btn_vec_t       pad_in [2];
  btn_vec_t       samp_q [2], samp_d [2];
  btn_vec_t       held_q [2], held_d [2];
  logic [7:0]     stab_q [2], stab_d [2];
  logic [NB2-1:0] rep_q, rep_d, held_flat, pend;
  logic           found, sel_pad, push, pop, full;
  logic [4:0]     pos;
  logic [3:0]     sel_idx;
  logic [EV_W-1:0] push_data;

  assign pad_in[0] = button_data_1;
  assign pad_in[1] = button_data_2;
  assign held_1    = held_q[0];
  assign held_2    = held_q[1];

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      samp_d[p] = pad_in[p];
      held_d[p] = held_q[p];
      if (pad_in[p] != samp_q[p])  stab_d[p] = 8'd1;
      else if (stab_q[p] == DEB)   stab_d[p] = stab_q[p];
      else                         stab_d[p] = stab_q[p] + 8'd1;
      if (stab_d[p] == DEB && pad_in[p] != held_q[p]) held_d[p] = pad_in[p];
    end
  end

  // Pad 1 occupies the low half, so a lowest-bit search gives pad 1 priority.
  assign held_flat = {held_q[1], held_q[0]};
  assign pend      = held_flat ^ rep_q;

  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = NB2; i > 0; i--) begin
      if (pend[i-1]) begin
        found = 1'b1;
        pos   = 5'(i - 1);
      end
    end
    sel_pad   = (pos >= 5'(NUM_BTN));
    sel_idx   = sel_pad ? 4'(pos - 5'(NUM_BTN)) : pos[3:0];
    push_data = pack_event(sel_pad, held_flat[pos], sel_idx);
    push      = found & (~full | pop);
    rep_d     = rep_q;
    if (push) rep_d[pos] = held_flat[pos];
  end

  assign pop = ev_valid & ev_ready;

  always_ff @(posedge clk) begin
    if (!res) begin
      for (int unsigned p = 0; p < 2; p++) begin
        samp_q[p] <= '0;
        stab_q[p] <= '0;
        held_q[p] <= '0;
      end
      rep_q <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        samp_q[p] <= samp_d[p];
        stab_q[p] <= stab_d[p];
        held_q[p] <= held_d[p];
      end
      rep_q <= rep_d;
    end
  end

  joypad_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (res),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (ev_data),
    .valid_o (ev_valid),
    .full_o  (full),
    .count_o (ev_count)
  );

endmodule
